// File: rtl/led_frame_scanner_pkg.sv
// led_frame_scanner_pkg: shared state encoding, default sizes and gap-counter width helper
package led_frame_scanner_pkg;

    typedef enum logic [2:0] {IDLE, MAP, READ, LATCH, SEND, GAP} state_t;

    localparam int LED_NUM_DEF = 64;
    localparam int PIX_W       = 24;
    localparam int RST_GAP_DEF = 15000;

    function automatic int gap_w(input int cycles);
        return cycles > 0 ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/led_frame_scanner_if.sv
// led_frame_scanner_if: frame control, mapper, pixel RAM and serializer handshake signals
interface led_frame_scanner_if #(
    parameter int IDX_W  = 6,
    parameter int DATA_W = led_frame_scanner_pkg::PIX_W
);
    logic              start, busy, done;
    logic [IDX_W-1:0]  idx, addr;
    logic              ram_rd_en;
    logic [IDX_W-1:0]  ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid, pix_ready;

    modport master (
        input  start, addr, ram_rd_data, pix_ready,
        output busy, done, idx, ram_rd_en, ram_rd_addr, pix_data, pix_valid
    );

    modport slave (
        output start, addr, ram_rd_data, pix_ready,
        input  busy, done, idx, ram_rd_en, ram_rd_addr, pix_data, pix_valid
    );
endinterface

// File: rtl/led_frame_scanner_gap_timer.sv
// led_gap_timer: loadable down-counter raising tc while it sits at zero after a load
module led_gap_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt;
    logic         run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            cnt <= load_val;
            run <= 1'b1;
        end else if (run) begin
            run <= cnt != '0;
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end

    assign tc = run && cnt == '0;
endmodule

// File: rtl/led_frame_scanner.sv
// led_frame_scanner: walks one frame of LEDs through mapper and RAM into the serializer, then the latch gap
module led_frame_scanner
    import led_frame_scanner_pkg::*;
#(
    parameter int LED_NUM        = LED_NUM_DEF,
    parameter int IDX_W          = 6,
    parameter int DATA_W         = PIX_W,
    parameter int RST_GAP_CYCLES = RST_GAP_DEF
) (
    input logic                clk,
    input logic                rst,
    led_frame_scanner_if.master bus
);
    localparam int               GW       = gap_w(RST_GAP_CYCLES);
    localparam logic [GW-1:0]    GAP_LOAD = GW'(RST_GAP_CYCLES > 0 ? RST_GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST     = IDX_W'(LED_NUM - 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] pix_data;
    logic              busy, done, rd_en, pix_valid, tc, gap_load;

    // The timer starts counting in the first GAP cycle; its tc schedules done one cycle later.
    assign gap_load = state == SEND && bus.pix_ready && idx == LAST && RST_GAP_CYCLES > 0;

    led_gap_timer #(.W(GW)) u_gap (
        .clk(clk),
        .rst(rst),
        .load(gap_load),
        .load_val(GAP_LOAD),
        .tc(tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            rd_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state <= MAP;
                    idx   <= '0;
                    busy  <= 1'b1;
                end
                MAP: begin
                    state <= READ;
                    rd_en <= 1'b1;
                end
                READ: begin
                    state <= LATCH;
                    rd_en <= 1'b0;
                end
                LATCH: begin
                    state     <= SEND;
                    pix_data  <= bus.ram_rd_data;
                    pix_valid <= 1'b1;
                end
                SEND: if (bus.pix_ready) begin
                    pix_valid <= 1'b0;
                    if (idx != LAST) begin
                        idx   <= idx + 1'b1;
                        state <= MAP;
                    end else if (RST_GAP_CYCLES > 0) begin
                        state <= GAP;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                GAP: if (done) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (tc) begin
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.idx         = idx;
    assign bus.ram_rd_en   = rd_en;
    assign bus.ram_rd_addr = bus.addr;
    assign bus.pix_data    = pix_data;
    assign bus.pix_valid   = pix_valid;
endmodule

// File: tb/tb_led_frame_scanner.sv
// tb_led_frame_scanner: frame-progress model plus directed scenarios for the LED frame scanner
module tb_led_frame_scanner;
    import led_frame_scanner_pkg::*;

    localparam int N    = 64;
    localparam int G    = 8;
    localparam int PEND = 4 * N + G + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_frame_scanner_if #(.IDX_W(6), .DATA_W(24)) a ();
    led_frame_scanner_if #(.IDX_W(6), .DATA_W(24)) b ();

    led_frame_scanner #(.LED_NUM(N), .IDX_W(6), .DATA_W(24), .RST_GAP_CYCLES(G)) dut_a (
        .clk(clk), .rst(rst), .bus(a)
    );
    led_frame_scanner #(.LED_NUM(1), .IDX_W(6), .DATA_W(24), .RST_GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .bus(b)
    );

    int checks = 0, errors = 0, cyc = 0;
    int ntx = 0, ndone = 0, p = 0, k;
    logic [23:0] last_data = '0;
    bit scurve = 1'b0;

    function automatic logic [5:0] mapf(input logic [5:0] i, input bit s);
        return (s && i[3]) ? {i[5:3], 3'd7 - i[2:0]} : i;
    endfunction

    function automatic logic [23:0] pix(input logic [5:0] ad);
        return {10'b0, ad, 2'b0, ad};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400 && !a.done; i++) tick();
        chk(name, a.done, 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Mapper (registered, 1-cycle latency) and pixel RAM (data the cycle after the strobe)
    always @(posedge clk) begin
        a.addr <= mapf(a.idx, scurve);
        if (a.ram_rd_en) a.ram_rd_data <= pix(a.ram_rd_addr);
        b.addr <= b.idx;
        if (b.ram_rd_en) b.ram_rd_data <= 24'hABCDEF ^ {18'b0, b.ram_rd_addr};
    end

    // p: cycles of frame progress, stalled SEND cycles excluded; 0 means idle
    always @(posedge clk or posedge rst) begin
        if (rst) p <= 0;
        else if (p == 0) p <= a.start ? 1 : 0;
        else if (p == PEND) p <= 0;
        else if (p <= 4 * N && p % 4 == 0 && !a.pix_ready) p <= p;
        else p <= p + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            k = (p - 1) / 4;
            chk("busy", a.busy, p != 0);
            chk("done", a.done, p == PEND);
            chk("valid", a.pix_valid, p >= 1 && p <= 4 * N && p % 4 == 0);
            chk("rd_en", a.ram_rd_en, p >= 1 && p <= 4 * N && p % 4 == 2);
            if (p >= 1 && p <= 4 * N) chk("idx", a.idx, k);
            if (p >= 1 && p <= 4 * N && p % 4 == 2) chk("rd_addr", a.ram_rd_addr, mapf(k[5:0], scurve));
            if (p >= 1 && p <= 4 * N && p % 4 == 0) chk("pix_data", a.pix_data, pix(mapf(k[5:0], scurve)));
            if (a.done) ndone++;
            if (a.pix_valid && a.pix_ready) begin
                ntx++;
                last_data = a.pix_data;
            end
        end
    end

    initial begin
        int ts, td, n0, d0;
        logic [23:0] d;
        a.start = 0; a.pix_ready = 1; b.start = 0; b.pix_ready = 1;
        tick(); tick();
        chk("rst flags", {a.busy, a.done, a.pix_valid, a.ram_rd_en}, 0);
        chk("rst idx", a.idx, 0);
        chk("rst pix", a.pix_data, 0);
        rst = 0;
        tick();

        // identity mapper, ready high
        n0 = ntx;
        a.start = 1; ts = cyc; tick(); a.start = 0;
        tick(); tick(); tick();
        chk("t1 first valid", a.pix_valid, 1);
        chk("t1 first data", a.pix_data, 24'h000000);
        wait_done("t1 done seen");
        td = cyc;
        chk("t1 done time", td - ts, 265);
        chk("t1 count", ntx - n0, 64);
        chk("t1 last data", last_data, 24'h003F3F);
        tick();
        chk("t1 busy after", a.busy, 0);
        chk("t1 done pulse", a.done, 0);

        // S-curve mapper with a stall on pixel 5
        scurve = 1; n0 = ntx;
        a.start = 1; tick(); a.start = 0;
        for (int i = 0; i < 100 && a.idx != 5; i++) tick();
        a.pix_ready = 0;
        for (int i = 0; i < 10 && !a.pix_valid; i++) tick();
        chk("t3 valid", a.pix_valid, 1);
        d = a.pix_data;
        chk("t3 data", d, 24'h000505);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3 hold valid", a.pix_valid, 1);
            chk("t3 hold data", a.pix_data, d);
            chk("t3 hold idx", a.idx, 5);
        end
        chk("t3 no xfer", ntx - n0, 5);
        a.pix_ready = 1;
        tick();
        chk("t3 one xfer", ntx - n0, 6);
        chk("t3 next idx", a.idx, 6);
        for (int i = 0; i < 100 && !(a.ram_rd_en && a.idx == 8); i++) tick();
        chk("t2 idx8 addr", a.ram_rd_addr, 6'h0F);
        for (int i = 0; i < 100 && !(a.ram_rd_en && a.idx == 15); i++) tick();
        chk("t2 idx15 addr", a.ram_rd_addr, 6'h08);
        wait_done("t2 done seen");
        chk("t2 count", ntx - n0, 64);
        tick();
        scurve = 0;

        // stray starts mid-frame and in the gap, then back-to-back frames
        d0 = ndone;
        a.start = 1; tick(); a.start = 0;
        for (int i = 0; i < 200 && a.idx != 20; i++) tick();
        a.start = 1; tick(); a.start = 0;
        for (int i = 0; i < 300 && p <= 4 * N; i++) tick();
        a.start = 1; tick(); a.start = 0;
        wait_done("t4 done seen");
        tick(); tick(); tick();
        chk("t4 one done", ndone - d0, 1);
        chk("t4 idle", a.busy, 0);
        a.start = 1;
        wait_done("t4 b2b first");
        tick();
        chk("t4 gap to next", a.busy, 0);
        tick();
        chk("t4 next busy", a.busy, 1);
        chk("t4 next idx", a.idx, 0);
        a.start = 0;
        wait_done("t4 b2b second");
        tick(); tick();
        chk("t4 done count", ndone - d0, 3);

        // asynchronous reset in SEND at idx 30
        a.start = 1; tick(); a.start = 0;
        for (int i = 0; i < 200 && a.idx != 30; i++) tick();
        a.pix_ready = 0;
        for (int i = 0; i < 10 && !a.pix_valid; i++) tick();
        chk("t5 in send", a.pix_valid, 1);
        d0 = ndone;
        #1 rst = 1;
        #1;
        chk("t5 rst flags", {a.busy, a.done, a.pix_valid, a.ram_rd_en}, 0);
        chk("t5 rst idx", a.idx, 0);
        chk("t5 rst pix", a.pix_data, 0);
        tick(); tick();
        rst = 0; a.pix_ready = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("t5 no done", ndone - d0, 0);
        a.start = 1; tick(); a.start = 0;
        tick(); tick(); tick();
        chk("t5 restart valid", a.pix_valid, 1);
        chk("t5 restart idx", a.idx, 0);
        chk("t5 restart data", a.pix_data, 24'h000000);
        wait_done("t5 done seen");
        tick();

        // single-LED frame without gap
        b.start = 1; tick(); b.start = 0;
        tick(); tick();
        chk("t6 not yet", b.pix_valid, 0);
        tick();
        chk("t6 valid", b.pix_valid, 1);
        chk("t6 data", b.pix_data, 24'hABCDEF);
        chk("t6 busy", b.busy, 1);
        tick();
        chk("t6 done", b.done, 1);
        chk("t6 idle", {b.busy, b.pix_valid}, 0);
        tick();
        chk("t6 done pulse", b.done, 0);
        chk("t6 stays idle", b.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_frame_scanner.md
Name: led_frame_scanner

Overview:
- Sequences one display frame: walks LED index 0..LED_NUM-1 through the index-to-address mapper, reads each pixel from the frame RAM at the mapped address and hands it to the serial LED encoder over a valid/ready handshake.
- Inserts the latch/reset gap after the last pixel, then pulses done.
- Sits between the frame-start source, the mapper, the pixel RAM and the NeoPixel bit serializer.

Parameters:
- LED_NUM, 64, LEDs per frame (1..2^IDX_W)
- IDX_W, 6, index and RAM address width
- DATA_W, 24, pixel width (GRB)
- RST_GAP_CYCLES, 15000, idle cycles after the last pixel (300 us at 50 MHz); 0 = no gap

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-high reset
- start_in  in  1  frame request; sampled only in IDLE
- busy_out  out  1  high in every state except IDLE
- done_out  out  1  one-cycle pulse at frame completion
- idx_out  out  IDX_W  LED index to mapper
- addr_in  in  IDX_W  mapped address from mapper (registered in mapper, 1-cycle latency)
- ram_rd_en_out  out  1  RAM read strobe
- ram_rd_addr_out  out  IDX_W  RAM read address, driven combinationally from addr_in
- ram_rd_data_in  in  DATA_W  RAM read data, valid the cycle after ram_rd_en_out
- pix_data_out  out  DATA_W  pixel to serializer
- pix_valid_out  out  1  pixel valid
- pix_ready_in  in  1  serializer accepts

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-high on rst_in.
- Reset values (asserted at any time, including mid-frame):
  - state = IDLE; idx_out = 0; pix_data_out = 0.
  - pix_valid_out, ram_rd_en_out, busy_out, done_out = 0.
  - gap counter = 0.
  - No done pulse is generated for an aborted frame.
- States: IDLE, MAP, READ, LATCH, SEND, GAP.
- IDLE:
  - start_in = 1 → MAP, idx_out = 0.
  - start_in is ignored in every other state; there is no queuing.
- MAP: holds idx_out stable for one cycle while the mapper registers it → READ.
- READ: ram_rd_en_out = 1, ram_rd_addr_out = addr_in → LATCH.
- LATCH: pix_data_out <= ram_rd_data_in → SEND.
- SEND:
  - pix_valid_out = 1.
  - pix_data_out is held stable while pix_ready_in = 0 (unbounded stall allowed).
  - On pix_valid_out && pix_ready_in:
    - if idx_out == LED_NUM-1: go to GAP, or to IDLE with a done pulse if RST_GAP_CYCLES == 0.
    - else: idx_out += 1, go to MAP.
- GAP:
  - The counter counts from 0 to RST_GAP_CYCLES-1; all outputs are idle.
  - At terminal count: done_out = 1 for exactly that cycle, then IDLE.
  - done_out and busy_out are both high in that final cycle.
- Latency:
  - start_in sampled at cycle T → first pix_valid_out at T+4.
  - With pix_ready_in tied high: 4 cycles per pixel.
  - Full frame with ready tied high: 1 + 4·LED_NUM + RST_GAP_CYCLES cycles from start to done.
- Width rules:
  - idx_out never exceeds LED_NUM-1 and never wraps.
  - The gap counter width is clog2(RST_GAP_CYCLES+1), minimum 1.
- LED_NUM = 1: a frame is a single MAP/READ/LATCH/SEND pass.
- start_in held high continuously: back-to-back frames. The next frame begins on the cycle after the done pulse, when IDLE resamples start_in.
- The mapper reset is driven separately; this block only requires addr_in to be valid one cycle after idx_out changes.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, MAP, READ, LATCH, SEND, GAP);
  - default constants LED_NUM_DEF = 64, PIX_W = 24, RST_GAP_DEF = 15000.
- One natural sub-module: led_gap_timer, a loadable down-counter with a terminal-count pulse (reusable by the serializer for its own reset low time).
- Everything else is in a single FSM module.

Test Plan:
1. Identity mapper, RAM[i] = 24'h000100·i + i, ready tied high, RST_GAP_CYCLES = 8, start pulse at T:
   - first pix_valid at T+4 with data 24'h000000;
   - 64 pixels delivered in order, last 24'h003F3F;
   - done pulse at T+1+256+8;
   - busy low the cycle after.
2. S-curve mapper (row 1 reversed):
   - idx 8 → ram_rd_addr_out 6'h0F;
   - idx 15 → 6'h08;
   - pixel sequence matches the reversed addresses for rows 1, 3, 5, 7.
3. Ready low for 10 cycles during pixel 5:
   - pix_valid stays high;
   - pix_data_out is unchanged throughout;
   - idx_out stays at 5;
   - exactly one transfer occurs when ready rises.
4. start_in pulsed again mid-frame and during GAP:
   - ignored;
   - exactly one done per frame;
   - start held high gives a second frame beginning the cycle after done.
5. rst_in asserted in SEND at idx 30:
   - all outputs 0 immediately (asynchronous);
   - no done pulse;
   - a new start restarts at idx 0.
6. LED_NUM = 1, RST_GAP_CYCLES = 0:
   - a single pixel is transferred;
   - done in the handshake-following cycle;
   - state returns to IDLE.
